// File: rtl/rtc_event_unit.sv
// RTC event/interrupt stage: sticky per-source status with enables driving one
// level interrupt, plus a show-ahead FIFO of timestamped event records.
module rtc_event_unit #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          timer_flag_i,
   input  logic                          alarm_flag_i,
   input  logic [21:0]                   clock_i,
   input  logic [31:0]                   date_i,
   input  logic [1:0]                    irq_enable_i,
   input  logic [1:0]                    status_clr_i,
   output logic [1:0]                    status_o,
   output logic                          irq_o,
   output logic                          evt_valid_o,
   input  logic                          evt_pop_i,
   output logic [1:0]                    evt_id_o,
   output logic [21:0]                   evt_clock_o,
   output logic [31:0]                   evt_date_o,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count_o,
   output logic                          evt_overflow_o,
   input  logic                          overflow_clr_i
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic          tf_q, af_q;
   logic [1:0]    status;
   logic          overflow;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   // record layout: {id[1:0], clock[21:0], date[31:0]}
   logic [55:0]   mem [FIFO_DEPTH];

   logic rise_t, rise_a, push, pop, full, wr_en, ovf_set;

   assign rise_t  = timer_flag_i & ~tf_q;
   assign rise_a  = alarm_flag_i & ~af_q;
   assign push    = rise_t | rise_a;
   assign pop     = evt_pop_i & (count != '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   // a pop on the same edge frees the slot, so a full FIFO still accepts
   assign wr_en   = push & (~full | pop);
   assign ovf_set = push & full & ~pop;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         tf_q     <= 1'b0;
         af_q     <= 1'b0;
         status   <= '0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         tf_q     <= timer_flag_i;
         af_q     <= alarm_flag_i;
         status   <= (status & ~status_clr_i) | {rise_a, rise_t};
         overflow <= ovf_set | (overflow & ~overflow_clr_i);
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset; empty outputs are masked below
   always_ff @(posedge clk_i) begin
      if (rstn_i && wr_en) mem[wr_ptr] <= {rise_a, rise_t, clock_i, date_i};
   end

   assign status_o       = status;
   assign irq_o          = |(status & irq_enable_i);
   assign evt_valid_o    = (count != '0);
   assign evt_count_o    = count;
   assign evt_overflow_o = overflow;
   assign evt_id_o       = evt_valid_o ? mem[rd_ptr][55:54] : 2'b00;
   assign evt_clock_o    = evt_valid_o ? mem[rd_ptr][53:32] : 22'h0;
   assign evt_date_o     = evt_valid_o ? mem[rd_ptr][31:0]  : 32'h0;

endmodule

// File: tb/tb_rtc_event_unit.sv
// Bench for rtc_event_unit: queue-based reference model checked every cycle,
// plus directed literal expectations from the test plan.
module tb_rtc_event_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        tf, af;
   logic [21:0] clock_w;
   logic [31:0] date_w;
   logic [1:0]  en, sclr;
   logic [1:0]  status;
   logic        irq, valid, pop, ovf, oclr;
   logic [1:0]  id;
   logic [21:0] eclk;
   logic [31:0] edate;
   logic [2:0]  cnt;

   int tests = 0;
   int fails = 0;
   bit check_en = 0;

   rtc_event_unit #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rstn_i(rstn), .timer_flag_i(tf), .alarm_flag_i(af),
      .clock_i(clock_w), .date_i(date_w), .irq_enable_i(en), .status_clr_i(sclr),
      .status_o(status), .irq_o(irq), .evt_valid_o(valid), .evt_pop_i(pop),
      .evt_id_o(id), .evt_clock_o(eclk), .evt_date_o(edate), .evt_count_o(cnt),
      .evt_overflow_o(ovf), .overflow_clr_i(oclr)
   );

   always #5 clk = ~clk;

   // reference model: records as {id, clock, date} in a queue
   logic [55:0] q[$];
   logic [1:0]  m_status;
   logic        m_ovf, m_tf, m_af;

   always @(posedge clk) begin
      if (!rstn) begin
         q.delete();
         m_status = 2'b00;
         m_ovf = 1'b0;
         m_tf = 1'b0;
         m_af = 1'b0;
      end else begin
         logic rt, ra, overflowed;
         rt = tf && !m_tf;
         ra = af && !m_af;
         overflowed = 1'b0;
         if (pop && q.size() > 0) void'(q.pop_front());
         if (rt || ra) begin
            if (q.size() < DEPTH) q.push_back({ra, rt, clock_w, date_w});
            else overflowed = 1'b1;
         end
         m_ovf = overflowed || (m_ovf && !oclr);
         m_status = (m_status & ~sclr) | {ra, rt};
         m_tf = tf;
         m_af = af;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         logic [55:0] h;
         h = (q.size() > 0) ? q[0] : 56'h0;
         chk("m_status", 64'(status), 64'(m_status));
         chk("m_irq",    64'(irq),    64'(|(m_status & en)));
         chk("m_valid",  64'(valid),  64'(q.size() > 0));
         chk("m_count",  64'(cnt),    64'(q.size()));
         chk("m_ovf",    64'(ovf),    64'(m_ovf));
         chk("m_id",     64'(id),     64'(h[55:54]));
         chk("m_clock",  64'(eclk),   64'(h[53:32]));
         chk("m_date",   64'(edate),  64'(h[31:0]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one event: flag(s) high for a single edge, then low for one edge
   task automatic ev(input logic t, input logic a, input logic [21:0] c, input logic [31:0] d);
      tf = t; af = a; clock_w = c; date_w = d;
      tick();
      tf = 0; af = 0;
      tick();
   endtask

   task automatic pop_one();
      pop = 1; tick(); pop = 0;
   endtask

   initial begin
      rstn = 0; tf = 0; af = 0; clock_w = '0; date_w = '0;
      en = 2'b00; sclr = 2'b00; pop = 0; oclr = 0;
      tick(); tick();
      rstn = 1;
      check_en = 1;
      chk("rst_status", 64'(status), 0);
      chk("rst_count",  64'(cnt), 0);
      chk("rst_valid",  64'(valid), 0);

      // single timer event
      tf = 1; clock_w = 22'h012345; date_w = 32'h20240315; en = 2'b01;
      tick();
      tf = 0;
      chk("t1_status", 64'(status), 1);
      chk("t1_irq",    64'(irq), 1);
      chk("t1_valid",  64'(valid), 1);
      chk("t1_id",     64'(id), 1);
      chk("t1_clock",  64'(eclk), 64'h012345);
      chk("t1_date",   64'(edate), 64'h20240315);
      chk("t1_count",  64'(cnt), 1);
      sclr = 2'b01; tick(); sclr = 0;
      chk("t1_clr_status", 64'(status), 0);
      chk("t1_clr_irq",    64'(irq), 0);
      chk("t1_clr_count",  64'(cnt), 1);
      pop_one(); tick();
      chk("t1_pop_count", 64'(cnt), 0);
      chk("t1_pop_clock", 64'(eclk), 0);

      // level flag held 10 cycles gives one record
      tf = 1; clock_w = 22'h000111;
      repeat (10) tick();
      tf = 0; tick();
      chk("lvl_count", 64'(cnt), 1);
      pop_one(); sclr = 2'b11; tick(); sclr = 0;

      // simultaneous rises
      ev(1, 1, 22'h000222, 32'h00000222);
      chk("both_id",     64'(id), 3);
      chk("both_status", 64'(status), 3);
      chk("both_count",  64'(cnt), 1);
      pop_one(); sclr = 2'b11; tick(); sclr = 0;

      // enable masking, combinational enable path
      en = 2'b01;
      ev(0, 1, 22'h000333, 32'h00000333);
      chk("mask_status", 64'(status), 2);
      chk("mask_irq",    64'(irq), 0);
      en = 2'b11; #1;
      chk("mask_irq_en", 64'(irq), 1);
      pop_one(); sclr = 2'b11; tick(); sclr = 0; en = 2'b01;

      // overflow: five events, no pops
      for (int i = 1; i <= 5; i++) ev(1, 0, 22'(22'h100 + i), 32'(32'h1000 + i));
      chk("ovf_count", 64'(cnt), 4);
      chk("ovf_flag",  64'(ovf), 1);
      chk("ovf_head",  64'(eclk), 64'h101);
      // a new overflow beats a simultaneous clear
      tf = 1; oclr = 1; clock_w = 22'h1FF; tick(); tf = 0; oclr = 0;
      chk("ovf_race", 64'(ovf), 1);
      chk("ovf_race_head", 64'(eclk), 64'h101);
      oclr = 1; tick(); oclr = 0;
      chk("ovf_clr", 64'(ovf), 0);
      repeat (4) pop_one();
      chk("drain_count", 64'(cnt), 0);

      // push and pop together while full
      for (int i = 1; i <= 4; i++) ev(1, 0, 22'(22'h200 + i), 32'(32'h2000 + i));
      tf = 1; pop = 1; clock_w = 22'h205; date_w = 32'h2005;
      tick();
      tf = 0; pop = 0;
      chk("pp_count", 64'(cnt), 4);
      chk("pp_ovf",   64'(ovf), 0);
      for (int i = 2; i <= 5; i++) begin
         chk("pp_order", 64'(eclk), 64'(22'h200 + i));
         pop_one();
      end
      chk("pp_empty", 64'(cnt), 0);

      // status clear racing a new rise, then pop while empty
      sclr = 2'b11; tick(); sclr = 0;
      tf = 1; sclr = 2'b01; tick(); tf = 0; sclr = 0;
      chk("clr_race", 64'(status[0]), 1);
      pop_one(); tick();
      pop_one(); tick();
      chk("pop_empty_count", 64'(cnt), 0);
      chk("pop_empty_id",    64'(id), 0);

      // reset with 3 records, overflow and both status bits set
      for (int i = 1; i <= 3; i++) ev(1, 0, 22'(22'h300 + i), 32'(32'h3000 + i));
      ev(0, 1, 22'h304, 32'h3004);
      ev(1, 0, 22'h305, 32'h3005);
      pop_one(); tick();
      chk("pre_rst_count",  64'(cnt), 3);
      chk("pre_rst_ovf",    64'(ovf), 1);
      chk("pre_rst_status", 64'(status), 3);
      rstn = 0; tick(); rstn = 1;
      chk("mid_rst_status", 64'(status), 0);
      chk("mid_rst_irq",    64'(irq), 0);
      chk("mid_rst_count",  64'(cnt), 0);
      chk("mid_rst_ovf",    64'(ovf), 0);
      chk("mid_rst_clock",  64'(eclk), 0);
      ev(1, 0, 22'h3AA, 32'h30AA);
      chk("post_rst_count", 64'(cnt), 1);
      chk("post_rst_clock", 64'(eclk), 64'h3AA);

      tick();
      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
